// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches a contiguous run of instruction words from
// instruction memory and drives each one to the datapath for a single commit.
module instr_sequencer #(
    parameter int IMEM_AW = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IMEM_AW-1:0] base_addr,
    input  logic [IMEM_AW:0]   length,
    input  logic               abort,
    input  logic               stall,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr,
    output logic               we,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [IMEM_AW-1:0] pc;
    logic [IMEM_AW:0]   remaining;
    logic               commit;

    // Commit is the only path that must react to stall/abort within the cycle.
    assign commit    = (state == EXEC) && !stall && !abort;

    assign we        = commit;
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            remaining <= '0;
            retired   <= '0;
            instr     <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        retired <= '0;
                        if (length != '0) begin
                            pc        <= base_addr;
                            remaining <= length;
                            state     <= FETCH;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        if (retired != '1) begin
                            retired <= retired + 1'b1;
                        end
                        remaining <= remaining - 1'b1;
                        pc        <= pc + 1'b1;
                        if (remaining == (IMEM_AW+1)'(1)) begin
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: scripted runs recorded per cycle, then
// compared against hand-computed cycle numbers, addresses and counts.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        stall = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  length = '0;
    logic        imem_req, imem_ack;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata, instr;
    logic        we, busy, done;
    logic [15:0] retired;

    logic        req2, we2, busy2, done2;
    logic [7:0]  addr2;
    logic [31:0] instr2;
    logic [1:0]  retired2;

    logic [7:0]  tb_cyc = '0;
    int          req_age = 0;
    int          ack_wait = 0;
    logic        ack_force = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    int stall_from = 0, stall_len = 0, abort_at = 0, rst_at = 0, restart_at = 0;

    logic        busy_h [0:63];
    logic        req_h  [0:63];
    logic        we_h   [0:63];
    logic        done_h [0:63];
    logic [31:0] instr_h[0:63];
    logic [15:0] ret_h  [0:63];
    logic [7:0]  addr_h [0:63];
    int          fetch_cyc[$];
    logic [7:0]  fetch_addr[$];
    int          we_cyc[$];
    int          done_cyc[$];
    int          req_total;
    int          twin_diff = 0;

    always #5 clk = ~clk;

    assign imem_ack   = (imem_req && (req_age >= ack_wait)) || ack_force;
    assign imem_rdata = {8'hA5, tb_cyc, 8'h00, imem_addr};

    always @(posedge clk) begin
        if (imem_req && !imem_ack) req_age <= req_age + 1;
        else                       req_age <= 0;
    end

    instr_sequencer #(.IMEM_AW(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .abort(abort), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .we(we),
        .busy(busy), .done(done), .retired(retired)
    );

    // Narrow-counter twin, driven identically, exposes retired saturation.
    instr_sequencer #(.IMEM_AW(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .abort(abort), .stall(stall), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr2), .we(we2),
        .busy(busy2), .done(done2), .retired(retired2)
    );

    task automatic run(input logic [7:0] b, input logic [8:0] n, input int ncyc);
        fetch_cyc.delete(); fetch_addr.delete(); we_cyc.delete(); done_cyc.delete();
        req_total = 0;
        @(posedge clk); #1;
        tb_cyc = 8'd0; base_addr = b; length = n; start = 1'b1;
        stall = 1'b0; abort = 1'b0; rst = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            tb_cyc = 8'(c);
            start  = (c == restart_at);
            if (c == restart_at) length = 9'd7;
            stall  = (c >= stall_from) && (c < stall_from + stall_len);
            abort  = (c == abort_at);
            rst    = (c == rst_at);
            @(negedge clk);
            busy_h[c] = busy; req_h[c] = imem_req; we_h[c] = we; done_h[c] = done;
            instr_h[c] = instr; ret_h[c] = retired; addr_h[c] = imem_addr;
            if (imem_req) req_total++;
            if (imem_req && imem_ack) begin
                fetch_cyc.push_back(c);
                fetch_addr.push_back(imem_addr);
            end
            if (we) we_cyc.push_back(c);
            if (done) done_cyc.push_back(c);
            if (req2 !== imem_req || addr2 !== imem_addr || instr2 !== instr ||
                we2 !== we || busy2 !== busy || done2 !== done) twin_diff++;
        end
        start = 0; stall = 0; abort = 0; rst = 0;
        stall_from = 0; stall_len = 0; abort_at = 0; rst_at = 0; restart_at = 0;
        ack_force = 1'b0; ack_wait = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b1; length = 9'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, imem_req, we, done} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, imem_req, we, done});
        end
        n_checks++;
        if (retired !== 16'd0 || retired2 !== 2'd0) begin
            n_fail++; $display("FAIL reset_retired: got %h/%h expected 0/0", retired, retired2);
        end
        n_checks++;
        if (instr !== 32'd0 || imem_addr !== 8'd0) begin
            n_fail++; $display("FAIL reset_instr_addr: got %h/%h expected 0/0", instr, imem_addr);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] ea [3];
        int         ew [3];
        ea = '{8'h10, 8'h11, 8'h12};
        ew = '{2, 4, 6};
        run(8'h10, 9'd3, 10);
        n_checks++;
        if (fetch_addr.size() != 3) begin
            n_fail++; $display("FAIL basic_fetch_count: got %0d expected 3", fetch_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (fetch_addr[i] !== ea[i]) begin
                    n_fail++; $display("FAIL basic_addr%0d: got %h expected %h", i, fetch_addr[i], ea[i]);
                end
            end
        end
        n_checks++;
        if (we_cyc.size() != 3) begin
            n_fail++; $display("FAIL basic_we_count: got %0d expected 3", we_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (we_cyc[i] != ew[i]) begin
                    n_fail++; $display("FAIL basic_we_cycle%0d: got %0d expected %0d", i, we_cyc[i], ew[i]);
                end
            end
        end
        n_checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 7) begin
            n_fail++; $display("FAIL basic_done: got %0d pulses first %0d expected 1 at 7",
                               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        n_checks++;
        if (ret_h[10] !== 16'd3 || retired2 !== 2'd3) begin
            n_fail++; $display("FAIL basic_retired: got %0d/%0d expected 3/3", ret_h[10], retired2);
        end
        n_checks++;
        if (instr_h[10] !== 32'hA5050012) begin
            n_fail++; $display("FAIL basic_instr_hold: got %h expected a5050012", instr_h[10]);
        end
        n_checks++;
        if (busy_h[8] !== 1'b0 || done_h[8] !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle_after: got busy %b done %b expected 0 0", busy_h[8], done_h[8]);
        end
    endtask

    task automatic test_stall();
        stall_from = 2; stall_len = 4; ack_force = 1'b1;
        run(8'h20, 9'd2, 11);
        n_checks++;
        if (we_cyc.size() != 2 || we_cyc[0] != 6 || we_cyc[1] != 8) begin
            n_fail++; $display("FAIL stall_we: got %0d pulses first %0d expected 2 at 6,8",
                               we_cyc.size(), (we_cyc.size() > 0) ? we_cyc[0] : -1);
        end
        n_checks++;
        if (instr_h[4] !== 32'hA5010020 || ret_h[4] !== 16'd0) begin
            n_fail++; $display("FAIL stall_hold: got %h ret %0d expected a5010020 ret 0", instr_h[4], ret_h[4]);
        end
        n_checks++;
        if (instr_h[8] !== 32'hA5070021) begin
            n_fail++; $display("FAIL stall_ack_ignored: got %h expected a5070021", instr_h[8]);
        end
        n_checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 9 || ret_h[11] !== 16'd2) begin
            n_fail++; $display("FAIL stall_done: got %0d pulses retired %0d expected 1 at 9 retired 2",
                               done_cyc.size(), ret_h[11]);
        end
    endtask

    task automatic test_wait_states();
        ack_wait = 2;
        run(8'h40, 9'd1, 7);
        for (int c = 1; c <= 3; c++) begin
            n_checks++;
            if (req_h[c] !== 1'b1 || addr_h[c] !== 8'h40) begin
                n_fail++; $display("FAIL wait_req_hold%0d: got req %b addr %h expected 1 40", c, req_h[c], addr_h[c]);
            end
        end
        n_checks++;
        if (we_cyc.size() != 1 || we_cyc[0] != 4 || instr_h[4] !== 32'hA5030040) begin
            n_fail++; $display("FAIL wait_exec: got %0d we instr %h expected 1 at 4 instr a5030040",
                               we_cyc.size(), instr_h[4]);
        end
    endtask

    task automatic test_wrap();
        run(8'hFF, 9'd2, 7);
        n_checks++;
        if (fetch_addr.size() != 2 || fetch_addr[0] !== 8'hFF || fetch_addr[1] !== 8'h00) begin
            n_fail++; $display("FAIL wrap_addr: got %0d fetches first %h expected ff,00",
                               fetch_addr.size(), (fetch_addr.size() > 0) ? fetch_addr[0] : 8'hxx);
        end
        n_checks++;
        if (ret_h[7] !== 16'd2) begin
            n_fail++; $display("FAIL wrap_retired: got %0d expected 2", ret_h[7]);
        end
    endtask

    task automatic test_zero_length();
        run(8'h33, 9'd0, 4);
        n_checks++;
        if (busy_h[1] !== 1'b1 || done_h[1] !== 1'b1 || busy_h[2] !== 1'b0 || done_h[2] !== 1'b0) begin
            n_fail++; $display("FAIL zero_busy_done: got %b%b %b%b expected 11 00",
                               busy_h[1], done_h[1], busy_h[2], done_h[2]);
        end
        n_checks++;
        if (req_total != 0 || we_cyc.size() != 0 || ret_h[1] !== 16'd0) begin
            n_fail++; $display("FAIL zero_no_fetch: got req %0d we %0d retired %0d expected 0 0 0",
                               req_total, we_cyc.size(), ret_h[1]);
        end
    endtask

    task automatic test_start_ignored();
        restart_at = 2;
        run(8'h50, 9'd2, 8);
        n_checks++;
        if (we_cyc.size() != 2 || done_cyc.size() != 1 || done_cyc[0] != 5) begin
            n_fail++; $display("FAIL start_ignored: got %0d we %0d done expected 2 we 1 done at 5",
                               we_cyc.size(), done_cyc.size());
        end
        n_checks++;
        if (ret_h[8] !== 16'd2) begin
            n_fail++; $display("FAIL start_ignored_retired: got %0d expected 2", ret_h[8]);
        end
    endtask

    task automatic test_abort();
        abort_at = 3;
        run(8'h60, 9'd4, 10);
        n_checks++;
        if (req_h[3] !== 1'b1 || we_h[3] !== 1'b0 || busy_h[4] !== 1'b0 || req_h[4] !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: got req3 %b we3 %b busy4 %b req4 %b expected 1 0 0 0",
                               req_h[3], we_h[3], busy_h[4], req_h[4]);
        end
        n_checks++;
        if (done_cyc.size() != 0 || we_cyc.size() != 1) begin
            n_fail++; $display("FAIL abort_no_done: got %0d done %0d we expected 0 done 1 we",
                               done_cyc.size(), we_cyc.size());
        end
        n_checks++;
        if (ret_h[10] !== 16'd1 || instr_h[4] !== 32'hA5010060) begin
            n_fail++; $display("FAIL abort_state: got retired %0d instr %h expected 1 a5010060",
                               ret_h[10], instr_h[4]);
        end
    endtask

    task automatic test_reset_mid_run();
        stall_from = 2; stall_len = 20; rst_at = 3; abort_at = 3; restart_at = 3;
        run(8'h70, 9'd3, 6);
        n_checks++;
        if (busy_h[3] !== 1'b1 || busy_h[4] !== 1'b0 || req_h[4] !== 1'b0 ||
            we_h[4] !== 1'b0 || done_h[4] !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_ctrl: got busy3 %b busy4 %b req %b we %b done %b expected 1 0 0 0 0",
                               busy_h[3], busy_h[4], req_h[4], we_h[4], done_h[4]);
        end
        n_checks++;
        if (ret_h[4] !== 16'd0 || instr_h[4] !== 32'd0 || addr_h[4] !== 8'd0) begin
            n_fail++; $display("FAIL rst_mid_state: got ret %0d instr %h addr %h expected 0 0 0",
                               ret_h[4], instr_h[4], addr_h[4]);
        end
        run(8'h20, 9'd1, 5);
        n_checks++;
        if (we_cyc.size() != 1 || done_cyc.size() != 1 || done_cyc[0] != 3 || ret_h[5] !== 16'd1) begin
            n_fail++; $display("FAIL rst_mid_rerun: got %0d we %0d done retired %0d expected 1 we done at 3 retired 1",
                               we_cyc.size(), done_cyc.size(), ret_h[5]);
        end
    endtask

    task automatic test_saturate();
        run(8'h00, 9'd5, 13);
        n_checks++;
        if (ret_h[13] !== 16'd5 || done_cyc.size() != 1 || done_cyc[0] != 11) begin
            n_fail++; $display("FAIL sat_wide: got retired %0d done pulses %0d expected 5 and done at 11",
                               ret_h[13], done_cyc.size());
        end
        n_checks++;
        if (retired2 !== 2'd3) begin
            n_fail++; $display("FAIL sat_narrow: got %0d expected 3", retired2);
        end
        n_checks++;
        if (twin_diff != 0) begin
            n_fail++; $display("FAIL twin_outputs: got %0d differing cycles expected 0", twin_diff);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wait_states();
        test_wrap();
        test_zero_length();
        test_start_ignored();
        test_abort();
        test_reset_mid_run();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
